// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
//
// Refills one cache block after a miss. The block is 8 x 16-bit words. The
// controller requests the 8 words from memory on consecutive cycles and writes
// each returned word into the data array. It then validates the block by
// writing its metadata byte.
//
// Address split (byte address): offset [3:0], index [10:4], tag [15:11].
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-low reset
//   miss_detected  in   miss request, sampled only while idle
//   miss_address   in   byte address of the missing line
//   mem_rd_en      out  memory read strobe, one word per cycle
//   mem_addr       out  word-aligned memory read address
//   mem_data_in    in   returned memory word
//   mem_data_valid in   mem_data_in valid; returns arrive in request order
//   data_wen       out  data-array write strobe
//   data_block_en  out  one-hot data-array block select
//   data_word_en   out  one-hot word select within the block
//   data_out       out  word written to the data array
//   meta_write     out  metadata-array write strobe
//   meta_block_en  out  one-hot metadata-array block select
//   meta_data      out  metadata byte {valid, 2'b00, tag}
//   fsm_busy       out  high while a fill is in progress
//   fill_done      out  one-cycle pulse when the fill completes
// -----------------------------------------------------------------------------
module cache_fill_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         miss_detected,
  input  logic [15:0]  miss_address,
  output logic         mem_rd_en,
  output logic [15:0]  mem_addr,
  input  logic [15:0]  mem_data_in,
  input  logic         mem_data_valid,
  output logic         data_wen,
  output logic [127:0] data_block_en,
  output logic [7:0]   data_word_en,
  output logic [15:0]  data_out,
  output logic         meta_write,
  output logic [127:0] meta_block_en,
  output logic [7:0]   meta_data,
  output logic         fsm_busy,
  output logic         fill_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_META = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] line_q, line_d;       // latched miss_address[15:4]
  logic [3:0]  req_cnt_q, req_cnt_d; // bit 3 set once all 8 words are requested
  logic [2:0]  ret_cnt_q, ret_cnt_d; // words returned so far in this fill

  logic [6:0]   index;
  logic [4:0]   tag;
  logic [127:0] block_onehot;

  // Index and tag are plain slices of the latched line address.
  assign index        = line_q[6:0];
  assign tag          = line_q[11:7];
  assign block_onehot = 128'd1 << index;

  // NOTE: reset is asynchronous and active-low. All state, including the
  // latched address, is cleared, so the outputs decode to zero straight away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then updates from pre-edge values, whatever the statement
      // order.
      state_q   <= state_d;
      line_q    <= line_d;
      req_cnt_q <= req_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output and next-state value gets a default
    // first. No path leaves one unassigned, so no latches are inferred.
    state_d       = state_q;
    line_d        = line_q;
    req_cnt_d     = req_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    mem_rd_en     = 1'b0;
    mem_addr      = '0;
    data_wen      = 1'b0;
    data_block_en = '0;
    data_word_en  = '0;
    data_out      = '0;
    meta_write    = 1'b0;
    meta_block_en = '0;
    meta_data     = '0;
    fsm_busy      = 1'b0;
    fill_done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (miss_detected) begin
          state_d   = S_FILL;
          line_d    = miss_address[15:4];
          req_cnt_d = '0;
          ret_cnt_d = '0;
        end
      end

      S_FILL: begin
        fsm_busy = 1'b1;
        // Requests go out back-to-back from the first FILL cycle.
        if (!req_cnt_q[3]) begin
          mem_rd_en = 1'b1;
          mem_addr  = {line_q, req_cnt_q[2:0], 1'b0};
          req_cnt_d = req_cnt_q + 4'd1;
        end
        // Returns can arrive with any latency or gap. Each one is written
        // through in the same cycle.
        if (mem_data_valid) begin
          data_wen      = 1'b1;
          data_out      = mem_data_in;
          data_word_en  = 8'd1 << ret_cnt_q;
          data_block_en = block_onehot;
          ret_cnt_d     = ret_cnt_q + 3'd1;
          if (ret_cnt_q == 3'd7) begin
            state_d = S_META;
          end
        end
      end

      S_META: begin
        fsm_busy      = 1'b1;
        meta_write    = 1'b1;
        meta_block_en = block_onehot;
        meta_data     = {1'b1, 2'b00, tag};
        fill_done     = 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
//
// Directed bench for cache_fill_ctrl. A small in-order memory model answers
// each request after a set latency, with optional random gaps. Inputs are
// driven on the falling edge. Outputs are sampled 1 ns later, well away from
// the rising edge.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_detected;
  logic [15:0]  miss_address;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_data_in;
  logic         mem_data_valid;
  logic         data_wen;
  logic [127:0] data_block_en;
  logic [7:0]   data_word_en;
  logic [15:0]  data_out;
  logic         meta_write;
  logic [127:0] meta_block_en;
  logic [7:0]   meta_data;
  logic         fsm_busy;
  logic         fill_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_detected  (miss_detected),
    .miss_address   (miss_address),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_valid (mem_data_valid),
    .data_wen       (data_wen),
    .data_block_en  (data_block_en),
    .data_word_en   (data_word_en),
    .data_out       (data_out),
    .meta_write     (meta_write),
    .meta_block_en  (meta_block_en),
    .meta_data      (meta_data),
    .fsm_busy       (fsm_busy),
    .fill_done      (fill_done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},     128'(mem_rd_en),     128'd0);
    check({tag, "_mem_addr"},  128'(mem_addr),      128'd0);
    check({tag, "_data_wen"},  128'(data_wen),      128'd0);
    check({tag, "_dblk_en"},   data_block_en,       128'd0);
    check({tag, "_word_en"},   128'(data_word_en),  128'd0);
    check({tag, "_data_out"},  128'(data_out),      128'd0);
    check({tag, "_meta_wr"},   128'(meta_write),    128'd0);
    check({tag, "_mblk_en"},   meta_block_en,       128'd0);
    check({tag, "_meta_data"}, 128'(meta_data),     128'd0);
    check({tag, "_busy"},      128'(fsm_busy),      128'd0);
    check({tag, "_done"},      128'(fill_done),     128'd0);
  endtask

  // One idle cycle. A stray valid may be driven; it must not be written.
  task automatic idle_step(input logic stray);
    @(negedge clk);
    miss_detected  = 1'b0;
    mem_data_valid = stray;
    mem_data_in    = 16'hDEAD;
    #1;
    check("idle_busy",    128'(fsm_busy),     128'd0);
    check("idle_wen",     128'(data_wen),     128'd0);
    check("idle_word_en", 128'(data_word_en), 128'd0);
    check("idle_dblk_en", data_block_en,      128'd0);
    check("idle_rd_en",   128'(mem_rd_en),    128'd0);
    check("idle_meta_wr", 128'(meta_write),   128'd0);
    check("idle_done",    128'(fill_done),    128'd0);
  endtask

  // A complete fill, starting with the idle cycle that presents the miss.
  //   exp_idx/exp_meta : hand-decoded block index and metadata byte
  //   lat              : cycles from a request to its return
  //   gapped           : space the returns 1..3 cycles apart at random
  //   busy_miss        : hold miss_detected high throughout FILL
  //   hold_miss        : keep miss_detected high in META (back-to-back)
  //   extra_valid      : drive a 9th valid during META
  //   abort_after      : assert reset after this many returns (0 = never)
  task automatic fill(input logic [15:0] addr, input int exp_idx, input logic [7:0] exp_meta,
                      input int lat, input logic gapped, input logic busy_miss,
                      input logic hold_miss, input logic extra_valid, input int abort_after);
    int          reqs;
    int          rets;
    int          cyc;
    int          next_ok;
    int          req_cyc [8];
    logic        v;
    logic [15:0] word;
    reqs    = 0;
    rets    = 0;
    cyc     = 0;
    next_ok = 0;

    @(negedge clk);
    miss_detected  = 1'b1;
    miss_address   = addr;
    mem_data_valid = 1'b0;
    #1;
    check("accept_busy", 128'(fsm_busy), 128'd0);
    check("accept_wen",  128'(data_wen), 128'd0);

    while (rets < 8 && cyc < 200) begin
      @(negedge clk);
      miss_detected = busy_miss;
      miss_address  = 16'($urandom);  // must not disturb the latched line
      v    = (rets < reqs) && (cyc >= req_cyc[rets] + lat) && (cyc >= next_ok);
      word = {addr[15:4], rets[2:0], 1'b0} ^ 16'h5A5A;
      mem_data_valid = v;
      mem_data_in    = v ? word : 16'($urandom);
      #1;
      check("fill_busy",    128'(fsm_busy),   128'd1);
      check("fill_meta_wr", 128'(meta_write), 128'd0);
      check("fill_done",    128'(fill_done),  128'd0);
      check("fill_rd_en",   128'(mem_rd_en),  128'(reqs < 8));
      if (reqs < 8) begin
        check("fill_mem_addr", 128'(mem_addr), 128'({addr[15:4], reqs[2:0], 1'b0}));
        req_cyc[reqs] = cyc;
        reqs++;
      end
      check("fill_wen", 128'(data_wen), 128'(v));
      if (v) begin
        check("fill_data_out", 128'(data_out),     128'(word));
        check("fill_word_en",  128'(data_word_en), 128'(8'd1 << rets));
        check("fill_dblk_en",  data_block_en,      128'd1 << exp_idx);
        rets++;
        next_ok = cyc + (gapped ? int'($urandom_range(3, 1)) : 1);
      end else begin
        check("fill_word_en_off", 128'(data_word_en), 128'd0);
        check("fill_dblk_en_off", data_block_en,      128'd0);
      end
      cyc++;

      if (abort_after != 0 && rets == abort_after) begin
        // Reset lands between edges with a valid pending. Everything drops at once.
        @(negedge clk);
        mem_data_valid = 1'b1;
        miss_detected  = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_all_zero("abort_async");
        @(posedge clk);
        #1;
        check_all_zero("abort_held");
        @(negedge clk);
        rst            = 1'b1;
        miss_detected  = 1'b0;
        mem_data_valid = 1'b0;
        repeat (3) idle_step(1'b0);
        return;
      end
    end

    if (rets < 8) begin
      check("fill_timeout", 128'(rets), 128'd8);
      return;
    end

    @(negedge clk);
    miss_detected  = hold_miss;
    mem_data_valid = extra_valid;
    mem_data_in    = 16'hBEEF;
    #1;
    check("meta_wr",      128'(meta_write),   128'd1);
    check("meta_blk_en",  meta_block_en,      128'd1 << exp_idx);
    check("meta_data",    128'(meta_data),    128'(exp_meta));
    check("meta_done",    128'(fill_done),    128'd1);
    check("meta_busy",    128'(fsm_busy),     128'd1);
    check("meta_wen",     128'(data_wen),     128'd0);
    check("meta_dblk_en", data_block_en,      128'd0);
    check("meta_rd_en",   128'(mem_rd_en),    128'd0);
  endtask

  initial begin
    rst            = 1'b0;
    miss_detected  = 1'b0;
    miss_address   = 16'h0000;
    mem_data_in    = 16'h0000;
    mem_data_valid = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_step(1'b0);

    // Basic fill: index 60, tag 0x14 -> meta 0x94; mem_addr A3C0..A3CE.
    fill(16'hA3C6, 60, 8'h94, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_step(1'b0);

    // Stray valid while idle.
    idle_step(1'b1);

    // Gapped returns: index 50, tag 0x0B -> meta 0x8B.
    fill(16'h5B27, 50, 8'h8B, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_step(1'b0);

    // Miss held during FILL: ignored, single meta write, idle afterwards.
    fill(16'h1234, 35, 8'h82, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_step(1'b0);
    idle_step(1'b0);

    // 9th valid during META is not written: index 13, tag 0x18 -> meta 0x98.
    fill(16'hC0DE, 13, 8'h98, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle_step(1'b1);

    // Reset after 3 returns abandons the fill.
    fill(16'h4444, 68, 8'h88, 4, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Normal fill of block 1 after the reset.
    fill(16'h0010, 1, 8'h80, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_step(1'b0);

    // Back-to-back fills of block 127 with the miss held continuously.
    fill(16'h07F0, 127, 8'h80, 2, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    fill(16'h07F0, 127, 8'h80, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    idle_step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
